// File: rtl/mmio_bridge_if.sv
// Core/DRAM data-port bundle seen by the MMIO bridge.
// The master side is the core plus DRAM; the slave side is the bridge that decodes and steers it.
interface mmio_bridge_if;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic [31:0] RamReadData;
  logic        RamWE;

  modport master (
    output DataAdr, WriteData, MemWrite, RamReadData,
    input  ReadData, RamWE
  );

  modport slave (
    input  DataAdr, WriteData, MemWrite, RamReadData,
    output ReadData, RamWE
  );
endinterface

// File: rtl/mmio_bridge.sv
// Address decoder steering core loads/stores to DRAM or to the LED, UART TX (with FIFO)
// and free-running timer peripherals in the 0x400 window.
module mmio_bridge #(
  parameter int UART_DIV   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  mmio_bridge_if.slave bus,
  output logic [7:0]   leds,
  output logic         uart_tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (UART_DIV > 2) ? $clog2(UART_DIV) : 1;
  localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(UART_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  uart_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [31:0]   timer;
  logic          overflow;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  logic is_ram, sel_led, sel_data, sel_stat, sel_timer;
  logic full, empty, busy, pop, push_req, push_ok, drop, baud_done;

  assign is_ram    = bus.DataAdr < 32'h0000_0400;
  assign sel_led   = bus.DataAdr == 32'h0000_0400;
  assign sel_data  = bus.DataAdr == 32'h0000_0404;
  assign sel_stat  = bus.DataAdr == 32'h0000_0408;
  assign sel_timer = bus.DataAdr == 32'h0000_040C;

  assign full      = count == DEPTH_C;
  assign empty     = count == '0;
  assign busy      = state != IDLE;
  assign pop       = (state == IDLE) && !empty;
  assign push_req  = bus.MemWrite && sel_data;
  // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && !push_ok;
  assign baud_done = baud_cnt == BAUD_LAST;

  always_comb begin
    bus.ReadData = '0;
    bus.RamWE    = 1'b0;
    if (is_ram) begin
      bus.RamWE    = bus.MemWrite;
      bus.ReadData = bus.RamReadData;
    end else if (sel_led) begin
      bus.ReadData = {24'b0, leds};
    end else if (sel_stat) begin
      bus.ReadData = {28'b0, overflow, busy, empty, full};
    end else if (sel_timer) begin
      bus.ReadData = timer;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds  <= '0;
      timer <= '0;
    end else begin
      if (bus.MemWrite && sel_led)
        leds <= bus.WriteData[7:0];
      if (bus.MemWrite && sel_timer)
        timer <= bus.WriteData;
      else
        timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= bus.WriteData[7:0];
  end

  // Overflow clear beats a simultaneous dropped push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (bus.MemWrite && sel_stat)
        overflow <= 1'b0;
      else if (drop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shift    <= fifo_mem[rd_ptr];
            baud_cnt <= '0;
            uart_tx  <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          uart_tx <= 1'b1;
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Memory-mapped I/O bridge between the `arm` core's data port and `dram`. It decodes `DataAdr` and passes low addresses through to `dram`. A small peripheral window holds three peripherals: an LED register, a free-running 32-bit timer, and a UART transmitter with a TX FIFO. It returns the selected read data to the core in the same cycle, so programs can emit results without a testbench watching the store port.

## Interface
Parameters:
- `UART_DIV`, 434, clock cycles per UART bit (≥2)
- `FIFO_DEPTH`, 4, TX FIFO entries (power of two)

Ports:
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `DataAdr`  in  32  data address from core
- `WriteData`  in  32  store data from core
- `MemWrite`  in  1  store strobe from core
- `ReadData`  out  32  load data to core
- `RamReadData`  in  32  read data from `dram`
- `RamWE`  out  1  write enable to `dram`
- `leds`  out  8  LED register
- `uart_tx`  out  1  serial output, 8N1, LSB first

## Operation
- Address map, full 32-bit compare:
  - `DataAdr < 0x400`: RAM. `RamWE = MemWrite`, `ReadData = RamReadData`.
  - `0x400` LED: R/W. A write latches `WriteData[7:0]`. A read returns `{24'b0, leds}`.
  - `0x404` UART_DATA: write-only. A write pushes `WriteData[7:0]` into the FIFO. A read returns 0.
  - `0x408` UART_STAT: a read returns `{28'b0, overflow, busy, empty, full}` (bits 3..0). Any write clears `overflow`.
  - `0x40C` TIMER: a read returns the current count. A write loads `WriteData`.
  - Any other address: read 0, write ignored, `RamWE = 0`.
- `RamWE` and `ReadData` are combinational from current inputs and registered state.
- All register writes occur on the rising edge when `MemWrite = 1`.
- TX FIFO:
  - A push is accepted if not full, or if a pop occurs in the same cycle.
  - A push to a full FIFO with no pop is dropped and sets sticky `overflow`.
  - `full` is set when count = `FIFO_DEPTH`. `empty` is set when count = 0.
  - Pointers wrap modulo `FIFO_DEPTH`.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: `uart_tx = 1`. If the FIFO is not empty, pop the head into the shift register and go to START.
  - START: `uart_tx = 0` for `UART_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `uart_tx = shift[idx]` for `UART_DIV` cycles per bit. Go to STOP after idx 7.
  - STOP: `uart_tx = 1` for `UART_DIV` cycles, then go to IDLE.
  - `busy` = (state ≠ IDLE).
- Timer:
  - Increments by 1 every cycle and wraps from `0xFFFFFFFF` to 0.
  - A write has priority over the increment. The loaded value is visible for one cycle, then increments.

## Timing
- Reset values: `leds = 0`, `uart_tx = 1`, FIFO empty, `overflow = 0`, timer = 0, FSM = IDLE, baud counter = 0, bit index = 0.
- Reset is asynchronous and takes effect mid-frame. Any frame in progress is abandoned, `uart_tx` returns to 1 immediately, and FIFO contents are discarded.
- UART latency:
  - Byte written at edge N with the FIFO empty and FSM in IDLE: the pop and START occur at edge N+1, so `uart_tx` falls after edge N+1.
  - One frame lasts exactly 10·`UART_DIV` cycles.
  - Back-to-back bytes: the STOP→IDLE transition costs one IDLE cycle before the next START, so the frame period is 10·`UART_DIV`+1 cycles.
- Simultaneous events:
  - Push and pop in the same cycle leave the count unchanged.
  - A write to UART_STAT clears `overflow` in the same cycle as a dropped push. The clear wins.
- Reads are combinational with no added latency. A UART_STAT read reflects state before the current edge.

## Test plan
- Reset: hold `reset = 0` for 3 cycles, then release. Require:
  - `leds = 0`, `uart_tx = 1`
  - UART_STAT read = `0x2`
  - TIMER read increments 0, 1, 2… from the first cycle after release.
- RAM passthrough: store 7 to `0x64`. Require `RamWE = 1` with `DataAdr = 100` and `WriteData = 7`. A load from `0x64` returns `RamReadData`. A store to `0x500` gives `RamWE = 0`.
- LED: store `0x1A5` to `0x400`. Require `leds = 0xA5` and a read of `0x400` = `0x000000A5`.
- UART frame (`UART_DIV = 4`): store `0x55` to `0x404`. Require:
  - `uart_tx` low at the cycle after the write edge.
  - Then bits 1,0,1,0,1,0,1,0, each 4 cycles, then high.
  - 40 cycles total. `busy = 1` throughout.
- Overflow (`UART_DIV = 4`, depth 4): issue 6 consecutive stores. Require:
  - The first store pops immediately and 4 are queued.
  - The 6th is dropped, setting UART_STAT = `0xD` (overflow, busy, full).
  - Exactly 5 frames are transmitted.
  - A write to `0x408` clears bit 3.
- Timer wrap and mid-frame reset:
  - Store `0xFFFFFFFE` to `0x40C`. Require reads of FFFFFFFE, FFFFFFFF, 0.
  - Assert `reset` during a DATA bit. Require `uart_tx = 1` immediately and no residual frame after release.
